load_store_unit: RTL and testbench

// Multi-cycle load/store unit between CPU datapath and data memory, replacing the single-cycle ram

---
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one CPU request at a time, driven onto a req/ack memory bus
// with lane-aligned data and byte enables; load data is extracted and sign/zero-extended.
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [1:0]        dbg_state
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUS = 2'd1, S_RESP = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [OFFW-1:0]   off_q;
    logic [31:0]       cnt_q;
    logic              mem_we_q;
    logic [XLEN-1:0]   mem_addr_q, mem_wdata_q, resp_rdata_q;
    logic [NB-1:0]     mem_be_q;
    logic [1:0]        resp_err_q;

    // Mask covering the low 8<<size bits; a shift of XLEN or more yields all ones.
    function automatic logic [XLEN-1:0] size_mask(input logic [1:0] size);
        logic [6:0] nbits;
        nbits = 7'd8 << size;
        return ~({XLEN{1'b1}} << nbits);
    endfunction

    logic            accept, illegal, misaligned, req_fault, timeout_hit;
    logic [1:0]      req_size, req_err;
    logic [OFFW-1:0] req_off;
    logic [NB-1:0]   be_base, be_d;
    logic [XLEN-1:0] wdata_d, ld_shift, ld_mask, ld_ext;
    logic            ld_sign;

    always_comb begin
        req_size = req_funct3[1:0];
        req_off  = req_addr[OFFW-1:0];
        accept   = req_valid && req_ready;
        illegal  = 1'b1;
        if (req_we) begin
            if (req_funct3 inside {3'b000, 3'b001, 3'b010}) illegal = 1'b0;
            if (XLEN == 64 && req_funct3 == 3'b011)           illegal = 1'b0;
        end else begin
            if (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) illegal = 1'b0;
            if (XLEN == 64 && req_funct3 inside {3'b011, 3'b110})           illegal = 1'b0;
        end
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
        // Illegal encoding takes precedence over alignment.
        req_err   = illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b00);
        req_fault = (req_err != 2'b00);
        case (req_size)
            2'd0:    be_base = NB'(8'h01);
            2'd1:    be_base = NB'(8'h03);
            2'd2:    be_base = NB'(8'h0F);
            default: be_base = NB'(8'hFF);
        endcase
        be_d    = be_base << req_off;
        wdata_d = (req_wdata & size_mask(req_size)) << {req_off, 3'b000};

        ld_shift = mem_rdata >> {off_q, 3'b000};
        ld_mask  = size_mask(size_q);
        ld_sign  = |(ld_shift & ld_mask & ~(ld_mask >> 1));
        ld_ext   = (ld_shift & ld_mask) | ((ld_sign && !uns_q) ? ~ld_mask : '0);

        timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = req_fault ? S_RESP : S_BUS;
            S_BUS:   if (mem_ack || timeout_hit) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE) && !reset;
        mem_req    = (state_q == S_BUS);
        resp_valid = (state_q == S_RESP);
        dbg_state  = state_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            size_q       <= '0;
            uns_q        <= 1'b0;
            off_q        <= '0;
            cnt_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 2'b00;
        end else if (state_q == S_IDLE && accept) begin
            size_q <= req_size;
            uns_q  <= req_funct3[2];
            off_q  <= req_off;
            cnt_q  <= '0;
            if (req_fault) begin
                resp_err_q   <= req_err;
                resp_rdata_q <= '0;
            end else begin
                mem_we_q    <= req_we;
                mem_addr_q  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                mem_be_q    <= be_d;
                mem_wdata_q <= req_we ? wdata_d : '0;
            end
        end else if (state_q == S_BUS) begin
            cnt_q <= cnt_q + 32'd1;
            if (mem_ack || timeout_hit) begin
                resp_err_q   <= mem_ack ? 2'b00 : 2'b10;
                resp_rdata_q <= (mem_ack && !mem_we_q) ? ld_ext : '0;
                mem_we_q     <= 1'b0;
                mem_addr_q   <= '0;
                mem_be_q     <= '0;
                mem_wdata_q  <= '0;
            end
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 32-bit instance (TIMEOUT=4) and a 64-bit instance
// (TIMEOUT=15) share one stimulus bus; sel64 chooses which one is driven and observed.
module tb_load_store_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sel64 = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, mem_ack = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [63:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    always #5 clock = ~clock;

    // 32-bit instance
    logic        r32_ready, r32_rv, r32_mreq, r32_mwe;
    logic [31:0] r32_rdata, r32_maddr, r32_mwdata;
    logic [1:0]  r32_err, r32_state;
    logic [3:0]  r32_be;

    load_store_unit #(.XLEN(32), .TIMEOUT(4)) u32 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid && !sel64), .req_ready(r32_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .resp_valid(r32_rv), .resp_rdata(r32_rdata), .resp_err(r32_err),
        .mem_req(r32_mreq), .mem_we(r32_mwe), .mem_addr(r32_maddr), .mem_be(r32_be),
        .mem_wdata(r32_mwdata), .mem_ack(mem_ack && !sel64), .mem_rdata(mem_rdata[31:0]),
        .dbg_state(r32_state)
    );

    // 64-bit instance
    logic        r64_ready, r64_rv, r64_mreq, r64_mwe;
    logic [63:0] r64_rdata, r64_maddr, r64_mwdata;
    logic [1:0]  r64_err, r64_state;
    logic [7:0]  r64_be;

    load_store_unit #(.XLEN(64), .TIMEOUT(15)) u64 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid && sel64), .req_ready(r64_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(r64_rv), .resp_rdata(r64_rdata), .resp_err(r64_err),
        .mem_req(r64_mreq), .mem_we(r64_mwe), .mem_addr(r64_maddr), .mem_be(r64_be),
        .mem_wdata(r64_mwdata), .mem_ack(mem_ack && sel64), .mem_rdata(mem_rdata),
        .dbg_state(r64_state)
    );

    wire        o_ready = sel64 ? r64_ready : r32_ready;
    wire        o_rv    = sel64 ? r64_rv    : r32_rv;
    wire        o_mreq  = sel64 ? r64_mreq  : r32_mreq;
    wire        o_mwe   = sel64 ? r64_mwe   : r32_mwe;
    wire [63:0] o_rdata = sel64 ? r64_rdata : {32'b0, r32_rdata};
    wire [63:0] o_maddr = sel64 ? r64_maddr : {32'b0, r32_maddr};
    wire [63:0] o_mwdat = sel64 ? r64_mwdata : {32'b0, r32_mwdata};
    wire [7:0]  o_be    = sel64 ? r64_be    : {4'b0, r32_be};
    wire [1:0]  o_err   = sel64 ? r64_err   : r32_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One request; ack_dly = bus cycles before ack (-1 = never ack). e_lat is the cycle
    // of resp_valid counting the accept cycle as 0.
    task automatic run(input string name, input logic we, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata, input int ack_dly,
                       input logic [63:0] rdata, input logic [63:0] e_addr,
                       input logic [63:0] e_be, input logic [63:0] e_wdata,
                       input logic [63:0] e_rdata, input logic [1:0] e_err,
                       input int e_lat, input int e_nreq);
        int nreq;
        int bus_idx;
        bit seen;
        nreq = 0; bus_idx = 0; seen = 1'b0;
        exp_q.push_back(e_rdata);
        @(negedge clock);
        check($sformatf("%s.ready", name), o_ready, 1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        mem_rdata = rdata;
        @(posedge clock);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (o_mreq) begin
                if (nreq == 0) begin
                    check($sformatf("%s.mem_addr", name), o_maddr, e_addr);
                    check($sformatf("%s.mem_be", name), {56'b0, o_be}, e_be);
                    check($sformatf("%s.mem_wdata", name), o_mwdat, e_wdata);
                    check($sformatf("%s.mem_we", name), o_mwe, we);
                end
                nreq++;
                if (bus_idx == ack_dly) mem_ack = 1'b1;
                bus_idx++;
            end
            if (o_rv) begin
                seen = 1'b1;
                check($sformatf("%s.latency", name), c, e_lat);
                check($sformatf("%s.rdata", name), o_rdata, exp_q.pop_front());
                check($sformatf("%s.err", name), o_err, e_err);
                check($sformatf("%s.req_cycles", name), nreq, e_nreq);
            end
        end
        if (!seen) begin
            check($sformatf("%s.resp_seen", name), 0, 1);
            void'(exp_q.pop_front());
        end
        @(negedge clock);
        mem_ack = 1'b0;
        check($sformatf("%s.pulse_one", name), o_rv, 0);
        check($sformatf("%s.ready_after", name), o_ready, 1);
        check($sformatf("%s.rdata_held", name), o_rdata, e_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            sel64 = s[0];
            #1;
            check("reset.ready", o_ready, 0);
            check("reset.mem_req", o_mreq, 0);
            check("reset.mem_we", o_mwe, 0);
            check("reset.resp_valid", o_rv, 0);
            check("reset.resp_rdata", o_rdata, 0);
            check("reset.resp_err", o_err, 0);
            check("reset.mem_be", o_be, 0);
            check("reset.mem_addr", o_maddr, 0);
        end
        sel64 = 1'b0;
        reset = 1'b0;

        run("lb",      0, 3'b000, 'h103, 0,            0, 'h80FF0000, 'h100, 'h8, 0,            'hFFFFFF80, 2'b00, 2, 1);
        run("sh",      1, 3'b001, 'h202, 'h1234ABCD,   0, 'hDEADBEEF, 'h200, 'hC, 'hABCD0000,   0,          2'b00, 2, 1);
        run("lw_mis",  0, 3'b010, 'h101, 0,           -1, 0,          0,     0,   0,            0,          2'b01, 1, 0);
        run("ld32",    0, 3'b011, 'h101, 0,           -1, 0,          0,     0,   0,            0,          2'b11, 1, 0);
        run("st_ill",  1, 3'b100, 'h200, 'h77,        -1, 0,          0,     0,   0,            0,          2'b11, 1, 0);
        run("lhu",     0, 3'b101, 'h102, 0,            1, 'h80010000, 'h100, 'hC, 0,            'h00008001, 2'b00, 3, 2);
        run("lh",      0, 3'b001, 'h102, 0,            0, 'h80010000, 'h100, 'hC, 0,            'hFFFF8001, 2'b00, 2, 1);
        run("lbu",     0, 3'b100, 'h101, 0,            0, 'h00009A00, 'h100, 'h2, 0,            'h0000009A, 2'b00, 2, 1);
        run("sb",      1, 3'b000, 'h203, 'h55AA,       0, 0,          'h200, 'h8, 'hAA000000,   0,          2'b00, 2, 1);
        run("sw",      1, 3'b010, 'h204, 'hCAFEF00D,   0, 0,          'h204, 'hF, 'hCAFEF00D,   0,          2'b00, 2, 1);
        run("lw_to",   0, 3'b010, 'h300, 0,           -1, 'h11223344, 'h300, 'hF, 0,            0,          2'b10, 5, 4);
        run("lw_late", 0, 3'b010, 'h300, 0,            2, 'h11223344, 'h300, 'hF, 0,            'h11223344, 2'b00, 4, 3);
        run("lw_edge", 0, 3'b010, 'h300, 0,            3, 'h11223344, 'h300, 'hF, 0,            'h11223344, 2'b00, 5, 4);

        // Reset while the bus cycle is outstanding, then a stray ack in IDLE.
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 'h300;
        @(posedge clock);
        #1;
        req_valid = 1'b0; req_addr = '0;
        @(negedge clock);
        check("rst.bus_req", o_mreq, 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst.mem_req", o_mreq, 0);
        check("rst.ready", o_ready, 0);
        check("rst.resp_valid", o_rv, 0);
        check("rst.resp_err", o_err, 0);
        reset = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            mem_ack = 1'b0;
            check("rst.no_resp", o_rv, 0);
            check("rst.no_req", o_mreq, 0);
        end
        run("after_rst", 0, 3'b010, 'h400, 0, 0, 'hA5A5A5A5, 'h400, 'hF, 0, 'hA5A5A5A5, 2'b00, 2, 1);

        sel64 = 1'b1;
        run("lwu64",  0, 3'b110, 'h14, 0,                      0, 64'h8765432100000000, 'h10, 'hF0, 0,                      64'h0000000087654321, 2'b00, 2, 1);
        run("lw64",   0, 3'b010, 'h14, 0,                      0, 64'h8765432100000000, 'h10, 'hF0, 0,                      64'hFFFFFFFF87654321, 2'b00, 2, 1);
        run("ld64",   0, 3'b011, 'h18, 0,                      1, 64'h0123456789ABCDEF, 'h18, 'hFF, 0,                      64'h0123456789ABCDEF, 2'b00, 3, 2);
        run("sd64",   1, 3'b011, 'h20, 64'hA5A55A5A0F0FF0F0,   0, 64'h1,                'h20, 'hFF, 64'hA5A55A5A0F0FF0F0,   0,                    2'b00, 2, 1);
        run("sw64",   1, 3'b010, 'h24, 64'hFFFFFFFF12345678,   0, 0,                    'h20, 'hF0, 64'h1234567800000000,   0,                    2'b00, 2, 1);
        run("ld_mis", 0, 3'b011, 'h1C, 0,                     -1, 0,                    0,    0,    0,                      0,                    2'b01, 1, 0);
        run("ill64",  0, 3'b111, 'h10, 0,                     -1, 0,                    0,    0,    0,                      0,                    2'b11, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
